// File: rtl/logic_depth_pkg.sv
// Shared constants and types for the logic-depth predictor scheduler.
package logic_depth_pkg;

  localparam int unsigned FAN_W   = 4;
  localparam int unsigned GATE_W  = 2;
  localparam int unsigned DEPTH_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} sched_state_t;

  typedef enum logic [GATE_W-1:0] {GATE_AND, GATE_OR, GATE_XOR, GATE_MUX} gate_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      int idx;
      idx = (int'(last_grant) + i) % int'(NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/logic_depth_sched.sv
// Time-shares one combinational depth predictor among NUM_REQ requesters and tracks the max depth.
module logic_depth_sched
  import logic_depth_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FAN_W-1:0]  req_fan_in,
  input  logic [NUM_REQ*FAN_W-1:0]  req_fan_out,
  input  logic [NUM_REQ*GATE_W-1:0] req_gate_type,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FAN_W-1:0]          pred_fan_in,
  output logic [FAN_W-1:0]          pred_fan_out,
  output logic [GATE_W-1:0]         pred_gate_type,
  input  logic [DEPTH_W-1:0]        pred_depth,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DEPTH_W-1:0]        rsp_depth,
  input  logic                      clear_max,
  output logic [DEPTH_W-1:0]        max_depth,
  output logic [ID_W-1:0]           max_id,
  output logic                      busy
);

  sched_state_t        state_q;
  logic [ID_W-1:0]     last_grant_q, cur_id_q, rsp_id_q, max_id_q;
  logic [FAN_W-1:0]    pred_fan_in_q, pred_fan_out_q;
  logic [GATE_W-1:0]   pred_gate_type_q;
  logic [DEPTH_W-1:0]  rsp_depth_q, max_depth_q;
  logic                rsp_valid_q;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req_ready = (state_q == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      last_grant_q     <= ID_W'(NUM_REQ - 1);
      cur_id_q         <= '0;
      pred_fan_in_q    <= '0;
      pred_fan_out_q   <= '0;
      pred_gate_type_q <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_id_q         <= '0;
      rsp_depth_q      <= '0;
      max_depth_q      <= '0;
      max_id_q         <= '0;
    end else begin
      if (clear_max) begin
        max_depth_q <= '0;
        max_id_q    <= '0;
      end
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            pred_fan_in_q    <= req_fan_in[int'(grant_id)*FAN_W +: FAN_W];
            pred_fan_out_q   <= req_fan_out[int'(grant_id)*FAN_W +: FAN_W];
            pred_gate_type_q <= req_gate_type[int'(grant_id)*GATE_W +: GATE_W];
            cur_id_q         <= grant_id;
            last_grant_q     <= grant_id;
            state_q          <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_depth_q <= pred_depth;
          rsp_id_q    <= cur_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
          // A coincident clear empties the tracker, so this capture must land regardless.
          if (clear_max || (pred_depth > max_depth_q)) begin
            max_depth_q <= pred_depth;
            max_id_q    <= cur_id_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pred_fan_in    = pred_fan_in_q;
  assign pred_fan_out   = pred_fan_out_q;
  assign pred_gate_type = pred_gate_type_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_depth      = rsp_depth_q;
  assign max_depth      = max_depth_q;
  assign max_id         = max_id_q;
  assign busy           = (state_q != IDLE);

endmodule
